// File: rtl/aoi4_test_pkg.sv
// ----------------------------------------------------------------------------
// aoi4_test_pkg
// Shared definitions for the AOI4 self-test driver and its bench:
//   - state_e       : sweep FSM encoding (IDLE=0, RUN=1, FINISH=2)
//   - NUM_VECTORS   : number of stimulus vectors in one sweep
//   - LAST_VEC      : index of the final vector
//   - work_t        : working results accumulated during a sweep
//   - aoi4_expected : golden model of Y = ~((A&B)|(C&D)) for vector {A,B,C,D}
// ----------------------------------------------------------------------------
package aoi4_test_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    localparam int          NUM_VECTORS = 16;
    localparam logic [3:0]  LAST_VEC    = 4'(NUM_VECTORS - 1);

    // Results gathered while a sweep runs; only published in FINISH.
    typedef struct packed {
        logic [4:0] cnt;    // mismatches seen so far (0..16)
        logic [3:0] first;  // vector index of the first mismatch
        logic       seen;   // a mismatch has been recorded this sweep
    } work_t;

    // v[3]=A, v[2]=B, v[1]=C, v[0]=D
    function automatic logic aoi4_expected(input logic [3:0] v);
        return ~((v[3] & v[2]) | (v[1] & v[0]));
    endfunction

endpackage

// File: rtl/aoi4_selftest_driver.sv
// ----------------------------------------------------------------------------
// aoi4_selftest_driver
// Drives all 16 A/B/C/D combinations into an external AOI4 cell, holds each
// vector SETTLE_CYCLES+1 cycles, samples the cell output on the last cycle of
// each hold and reports pass/fail, mismatch count and first failing vector.
//
// Parameters:
//   SETTLE_CYCLES  extra hold cycles per vector before Y_in is sampled (0..15)
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          one-cycle sweep request, honoured only in IDLE
//   abort          synchronous cancel of a running sweep (no done pulse)
//   Y_in           output of the AOI cell under test
//   A,B,C,D        stimulus bits 3..0 of the current vector (0 when idle)
//   busy           high while the sweep is running
//   done           one-cycle pulse when a sweep completes
//   pass           last completed sweep had zero mismatches
//   fail_count     mismatches in last completed sweep
//   first_fail_vec first mismatching vector of last completed sweep (0 if none)
//
// Handshake: start is a level sampled on each rising edge; it is acted on only
// when the FSM is IDLE (start beats abort there). While RUN, abort forces IDLE
// on the next edge and takes priority over the sample on that edge.
// ----------------------------------------------------------------------------
module aoi4_selftest_driver
    import aoi4_test_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       Y_in,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] fail_count,
    output logic [3:0] first_fail_vec
);

    localparam logic [3:0] HOLD_LAST = 4'(SETTLE_CYCLES);

    state_e     state_q, state_d;
    logic [3:0] vec_q, vec_d;
    logic [3:0] hold_q, hold_d;
    work_t      work_q, work_d;

    // Registered outputs, computed from next-state values so they line up
    // with the state they describe.
    logic [3:0] abcd_q, abcd_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [4:0] fcnt_q, fcnt_d;
    logic [3:0] ffv_q, ffv_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            hold_q  <= '0;
            work_q  <= '0;
            abcd_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fcnt_q  <= '0;
            ffv_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            work_q  <= work_d;
            abcd_q  <= abcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fcnt_q  <= fcnt_d;
            ffv_q   <= ffv_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hold_d  = hold_q;
        work_d  = work_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    vec_d   = '0;
                    hold_d  = '0;
                    work_d  = '0;
                end
            end

            RUN: begin
                if (abort) begin
                    // Working results are simply left behind; they are
                    // cleared again on the next start.
                    state_d = IDLE;
                    vec_d   = '0;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    // Y_in reflects the current vector, which has been
                    // stable for SETTLE_CYCLES+1 cycles by now.
                    hold_d = '0;
                    if (Y_in != aoi4_expected(vec_q)) begin
                        work_d.cnt = work_q.cnt + 5'd1;
                        if (!work_q.seen) begin
                            work_d.seen  = 1'b1;
                            work_d.first = vec_q;
                        end
                    end
                    if (vec_q == LAST_VEC) begin
                        state_d = FINISH;
                    end else begin
                        vec_d = vec_q + 4'd1;
                    end
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end

            FINISH: begin
                state_d = IDLE;
                vec_d   = '0;
            end

            default: begin
                state_d = IDLE;
                vec_d   = '0;
                hold_d  = '0;
            end
        endcase

        abcd_d = (state_d == RUN) ? vec_d : 4'd0;
        busy_d = (state_d == RUN);
        done_d = (state_d == FINISH);

        // Results are published when FINISH is entered, so they are valid
        // in the same cycle as the done pulse and hold at all other times.
        pass_d = pass_q;
        fcnt_d = fcnt_q;
        ffv_d  = ffv_q;
        if (state_d == FINISH) begin
            pass_d = (work_d.cnt == 5'd0);
            fcnt_d = work_d.cnt;
            ffv_d  = work_d.seen ? work_d.first : 4'd0;
        end
    end

    assign {A, B, C, D}   = abcd_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_count     = fcnt_q;
    assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_aoi4_selftest_driver.sv
module tb_aoi4_selftest_driver;
    import aoi4_test_pkg::*;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (SETTLE_CYCLES=2) with a configurable cell model
    logic       start = 1'b0, abort = 1'b0, y_main;
    logic       a_m, b_m, c_m, d_m, busy_m, done_m, pass_m;
    logic [4:0] fcnt_m;
    logic [3:0] ffv_m;
    int         cell_mode = 0;  // 0 = correct cell, 1 = Y stuck 0, 2 = Y stuck 1

    assign y_main = (cell_mode == 0) ? ~((a_m & b_m) | (c_m & d_m)) :
                    (cell_mode == 1) ? 1'b0 : 1'b1;

    aoi4_selftest_driver #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .Y_in(y_main),
        .A(a_m), .B(b_m), .C(c_m), .D(d_m), .busy(busy_m), .done(done_m),
        .pass(pass_m), .fail_count(fcnt_m), .first_fail_vec(ffv_m)
    );

    // Second DUT (SETTLE_CYCLES=0) with a correct cell
    logic       start0 = 1'b0, y0;
    logic       a0, b0, c0, d0, busy0, done0, pass0;
    logic [4:0] fcnt0;
    logic [3:0] ffv0;

    assign y0 = ~((a0 & b0) | (c0 & d0));

    aoi4_selftest_driver #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(1'b0), .Y_in(y0),
        .A(a0), .B(b0), .C(c0), .D(d0), .busy(busy0), .done(done0),
        .pass(pass0), .fail_count(fcnt0), .first_fail_vec(ffv0)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_main_outputs(input string tag, input logic [12:0] exp);
        check(tag, {a_m, b_m, c_m, d_m, busy_m, done_m, pass_m, fcnt_m, ffv_m[0]} , exp);
    endtask

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    // Start pulse on the main DUT; returns at the negedge of the first RUN cycle.
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 0;
    endtask

    // Monitor one sweep of the main DUT (SETTLE_CYCLES=2), checking the
    // stimulus sequence: vector i is held for 3 cycles.
    task automatic watch_sweep(input string tag, output int busy_n, output int done_n);
        int seq_err = 0;
        int tail_err = 0;
        busy_n = 0;
        done_n = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (busy_m) begin
                if ({a_m, b_m, c_m, d_m} !== 4'(busy_n / 3)) seq_err++;
                busy_n++;
            end
            if (done_m) begin
                done_n++;
                if ({a_m, b_m, c_m, d_m, busy_m} !== 5'b0) tail_err++;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_seq"}, seq_err, 0);
        check({tag, "_done_idle_outs"}, tail_err, 0);
    endtask

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    int bn, dn;

    initial begin
        // Golden-model table: bit v set when Y=1 for vector v.
        begin
            logic [15:0] tbl;
            for (int v = 0; v < 16; v++) tbl[v] = aoi4_expected(4'(v));
            check("pkg_expected_table", tbl, 16'h0777);
        end

        // Reset state
        #12;
        check("rst_main_outs", {a_m, b_m, c_m, d_m, busy_m, done_m, pass_m, fcnt_m, ffv_m}, 0);
        check("rst_dut0_outs", {a0, b0, c0, d0, busy0, done0, pass0, fcnt0, ffv0}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: correct cell
        cell_mode = 0;
        pulse_start();
        watch_sweep("t1", bn, dn);
        check("t1_busy_cycles", bn, 48);
        check("t1_done_pulses", dn, 1);
        check("t1_pass", pass_m, 1);
        check("t1_fail_count", fcnt_m, 0);
        check("t1_first_fail", ffv_m, 0);
        @(negedge clk);
        check("t1_done_one_cycle", done_m, 0);

        // Test 2: Y stuck at 0 -> the 9 vectors expecting 1 all mismatch
        cell_mode = 1;
        pulse_start();
        watch_sweep("t2", bn, dn);
        check("t2_busy_cycles", bn, 48);
        check("t2_pass", pass_m, 0);
        check("t2_fail_count", fcnt_m, 9);
        check("t2_first_fail", ffv_m, 0);

        // Test 3: Y stuck at 1 -> vectors 3,7,11..15 mismatch
        cell_mode = 2;
        pulse_start();
        // Results from test 2 must hold during the new sweep
        check("t3_hold_during_run", {pass_m, fcnt_m, ffv_m}, {1'b0, 5'd9, 4'd0});
        watch_sweep("t3", bn, dn);
        check("t3_done_pulses", dn, 1);
        check("t3_pass", pass_m, 0);
        check("t3_fail_count", fcnt_m, 7);
        check("t3_first_fail", ffv_m, 3);

        // Test 4: abort at RUN cycle 10
        cell_mode = 0;
        pulse_start();
        repeat (10) @(negedge clk);
        check("t4_busy_before_abort", busy_m, 1);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("t4_busy_after_abort", busy_m, 0);
        check("t4_abcd_after_abort", {a_m, b_m, c_m, d_m}, 0);
        check("t4_results_kept", {pass_m, fcnt_m, ffv_m}, {1'b0, 5'd7, 4'd3});
        begin
            int late = 0;
            for (int i = 0; i < 60; i++) begin
                if (done_m || busy_m) late++;
                @(negedge clk);
            end
            check("t4_no_done_or_busy", late, 0);
        end

        // Test 5: asynchronous reset mid-sweep
        cell_mode = 2;
        pulse_start();
        repeat (20) @(negedge clk);
        check("t5_busy_before_rst", busy_m, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_rst_outs", {a_m, b_m, c_m, d_m, busy_m, done_m, pass_m, fcnt_m, ffv_m}, 0);
        @(negedge clk) rst_n = 1'b1;
        cell_mode = 0;
        repeat (2) @(negedge clk);
        pulse_start();
        watch_sweep("t5", bn, dn);
        check("t5_busy_cycles", bn, 48);
        check("t5_done_pulses", dn, 1);
        check("t5_pass", pass_m, 1);
        check("t5_fail_count", fcnt_m, 0);

        // Test 6: SETTLE_CYCLES=0, extra starts during RUN are ignored
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        begin
            int b0n = 0, d0n = 0, seq0 = 0;
            for (int cyc = 0; cyc < 60; cyc++) begin
                if (busy0) begin
                    if ({a0, b0, c0, d0} !== 4'(b0n)) seq0++;
                    b0n++;
                end
                if (done0) d0n++;
                start0 = (cyc == 5 || cyc == 15);
                @(negedge clk);
            end
            check("t6_seq", seq0, 0);
            check("t6_busy_cycles", b0n, 16);
            check("t6_done_pulses", d0n, 1);
            check("t6_pass", pass0, 1);
            check("t6_fail_count", fcnt0, 0);
            check("t6_idle_after", busy0, 0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
